ws2812b_rx_decoder: RTL

//  Receive side of the WS2812B one-wire link: samples the NRZ line driven by ws2812b_controller,

---
 rtl/ws2812b_pkg.sv | 31 +++
 rtl/ws2812b_line_sync.sv | 34 +++
 rtl/ws2812b_rx_decoder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: receive FSM states, the default line timing
// at 50 MHz (also used by the controller bench) and the GRB word layout.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    S_RESYNC,
    S_IDLE,
    S_HIGH,
    S_LOW
  } rx_state_t;

  // Default line timing in 50 MHz clk cycles
  localparam int WS_T0H          = 20;
  localparam int WS_T1H          = 40;
  localparam int WS_TBIT         = 63;
  localparam int WS_RESET_CYCLES = 2500;

  // One pixel as it travels on the wire: green first, blue last
  typedef struct packed {
    logic [7:0] green;
    logic [7:0] red;
    logic [7:0] blue;
  } grb_t;

  function automatic logic [23:0] grb_pack(input logic [7:0] g,
                                           input logic [7:0] r,
                                           input logic [7:0] b);
    return {g, r, b};
  endfunction

endpackage

// File: rtl/ws2812b_line_sync.sv
// Brings the asynchronous WS2812B line into the clk domain through two
// flops, then keeps one more sample so single-cycle rise/fall strobes
// can be formed from the synchronized value.
module ws2812b_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic line,
  output logic rise,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Synchronizer chain plus edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      meta_reg <= pin;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign line = sync_reg;
  assign rise = sync_reg & ~prev_reg;
  assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/ws2812b_rx_decoder.sv
// WS2812B receiver: measures each high pulse on the synchronized line,
// shifts bits into a 24-bit GRB word and emits one pixel per word, then
// reports the frame size when the long low reset gap is seen.
// Build option: define WS2812B_RX_ERR_EN to flag glitches and stuck-high
// lines on bit_error; without it bit_error stays 0.
module ws2812b_rx_decoder
  import ws2812b_pkg::*;
#(
  parameter int NB_LEDS      = 12,
  parameter int BIT_THRESH   = 30,
  parameter int MIN_HIGH     = 8,
  parameter int RESET_CYCLES = WS_RESET_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_ws2812b,
  output logic       pixel_valid,
  output logic [7:0] pixel_index,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       frame_done,
  output logic [7:0] pixel_count,
  output logic       frame_overflow,
  output logic       bit_error
);

  // Counters must hold every timing constant they are compared with
  localparam int CNT_MAX_A = (RESET_CYCLES > BIT_THRESH) ? RESET_CYCLES : BIT_THRESH;
  localparam int CNT_MAX   = (CNT_MAX_A > MIN_HIGH) ? CNT_MAX_A : MIN_HIGH;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RESET_CNT  = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] THRESH_CNT = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] MIN_CNT    = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);
  localparam logic [7:0]       NB_CNT     = 8'(NB_LEDS);
  localparam logic [4:0]       LAST_BIT   = 5'd23;

`ifdef WS2812B_RX_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic             line;
  logic             rise;
  logic             fall;

  rx_state_t        state_reg;
  logic [CNT_W-1:0] high_cnt_reg;
  logic [CNT_W-1:0] low_cnt_reg;
  logic [4:0]       bit_cnt_reg;
  logic [23:0]      shift_reg;
  logic             word_done_reg;
  logic             frame_end_reg;
  logic             bit_error_reg;
  logic [7:0]       pix_cnt_reg;
  logic             overflow_reg;

  logic             rx_bit;
  logic             short_pulse;
  grb_t             word;

  ws2812b_line_sync u_line_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (data_ws2812b),
    .line  (line),
    .rise  (rise),
    .fall  (fall)
  );

  assign rx_bit      = (high_cnt_reg >= THRESH_CNT);
  assign short_pulse = ERR_EN && (high_cnt_reg < MIN_CNT);
  assign word        = grb_t'(shift_reg);
  assign bit_error   = bit_error_reg;

  // Line FSM: pulse-width measurement, bit assembly and gap detection
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_RESYNC;
      high_cnt_reg  <= '0;
      low_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      word_done_reg <= 1'b0;
      frame_end_reg <= 1'b0;
      bit_error_reg <= 1'b0;
    end else begin
      word_done_reg <= 1'b0;
      frame_end_reg <= 1'b0;
      bit_error_reg <= 1'b0;
      case (state_reg)
        S_RESYNC: begin
          // Only a full reset gap of quiet line proves we are between frames
          if (line) begin
            low_cnt_reg <= '0;
          end else if (low_cnt_reg == RESET_CNT) begin
            low_cnt_reg <= '0;
            state_reg   <= S_IDLE;
          end else begin
            low_cnt_reg <= low_cnt_reg + ONE_CNT;
          end
        end
        S_IDLE: begin
          if (rise) begin
            high_cnt_reg <= ONE_CNT;
            state_reg    <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (fall) begin
            low_cnt_reg <= ONE_CNT;
            state_reg   <= S_LOW;
            if (short_pulse) begin
              // Too short to be a real bit: keep the word intact
              bit_error_reg <= 1'b1;
            end else begin
              shift_reg <= {shift_reg[22:0], rx_bit};
              if (bit_cnt_reg == LAST_BIT) begin
                bit_cnt_reg   <= '0;
                word_done_reg <= 1'b1;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 5'd1;
              end
            end
          end else if (high_cnt_reg == RESET_CNT) begin
            // Line stuck high: abandon the partial word and wait for quiet
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            low_cnt_reg   <= '0;
            bit_error_reg <= ERR_EN;
            state_reg     <= S_RESYNC;
          end else begin
            high_cnt_reg <= high_cnt_reg + ONE_CNT;
          end
        end
        S_LOW: begin
          if (rise) begin
            high_cnt_reg <= ONE_CNT;
            state_reg    <= S_HIGH;
          end else if (low_cnt_reg == RESET_CNT) begin
            frame_end_reg <= 1'b1;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            low_cnt_reg   <= '0;
            state_reg     <= S_IDLE;
          end else begin
            low_cnt_reg <= low_cnt_reg + ONE_CNT;
          end
        end
        default: begin
          state_reg <= S_RESYNC;
        end
      endcase
    end
  end

  // Pixel and frame bookkeeping, one cycle behind the FSM events
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_valid    <= 1'b0;
      pixel_index    <= '0;
      red            <= '0;
      green          <= '0;
      blue           <= '0;
      frame_done     <= 1'b0;
      pixel_count    <= '0;
      frame_overflow <= 1'b0;
      pix_cnt_reg    <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (word_done_reg) begin
        if (pix_cnt_reg < NB_CNT) begin
          pixel_valid <= 1'b1;
          pixel_index <= pix_cnt_reg;
          green       <= word.green;
          red         <= word.red;
          blue        <= word.blue;
        end else begin
          overflow_reg <= 1'b1;
        end
        if (pix_cnt_reg != 8'hFF) begin
          pix_cnt_reg <= pix_cnt_reg + 8'd1;
        end
      end
      if (frame_end_reg) begin
        frame_done     <= 1'b1;
        pixel_count    <= (pix_cnt_reg < NB_CNT) ? pix_cnt_reg : NB_CNT;
        frame_overflow <= overflow_reg;
        pix_cnt_reg    <= '0;
        overflow_reg   <= 1'b0;
      end
    end
  end

endmodule
